bcd_countdown_timer: RTL
========================

Name: bcd_countdown_timer

Overview:
- Settable two-digit BCD seconds countdown (59..00) driven by board pushbuttons; counterpart to the free-running 00..59 up-counter display path.
- Debounces three active-low pushbuttons, loads a BCD preset from switches, and decrements once per divided 1 Hz tick while running.
- Flags expiry at 00.
- COUNT_O feeds the existing hex-to-seven-segment converters; status goes to LEDs.

Parameters:
- TICK_DIV_COUNT, 49999999: the tick divider counts 0..TICK_DIV_COUNT, giving one tick per TICK_DIV_COUNT+1 clocks (1 Hz at 50 MHz).
- DEBOUNCE_COUNT, 500000: number of consecutive stable synchronised samples required to accept a button change (10 ms).

Ports:
- CLOCK_50_I, input, 1: 50 MHz clock. All logic is on its rising edge.
- RESET_I, input, 1: asynchronous, active-high reset.
- START_N_I, input, 1: pushbutton, active-low. Start or resume.
- PAUSE_N_I, input, 1: pushbutton, active-low. Pause.
- LOAD_N_I, input, 1: pushbutton, active-low. Load preset.
- PRESET_I, input, 8: BCD preset from switches; [7:4] is tens, [3:0] is units.
- COUNT_O, output, 8: current BCD count; [7:4] is tens, [3:0] is units.
- RUNNING_O, output, 1: high while in RUN.
- EXPIRED_O, output, 1: high while in EXPIRED.
- TICK_O, output, 1: one-cycle pulse for each decrement.

Behaviour:
- Reset (asynchronous, dominates everything):
  - COUNT_O=8'h00, RUNNING_O=0, EXPIRED_O=0, TICK_O=0.
  - State is IDLE; divider and debounce counters are 0.
  - Synchroniser flops and debounced button levels are 1 (released).
  - Reset asserted mid-operation returns every output to these values immediately, without waiting for a clock edge.
- Button path, per button, identical:
  - A 2-flop synchroniser feeds a debounce counter.
  - The counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments; when it reaches DEBOUNCE_COUNT the debounced level takes the synchronised level and the counter clears.
  - A debounced 1->0 transition produces exactly one single-cycle press pulse. Release produces nothing; holding the button produces nothing further.
- Preset validity: valid only when tens<=5 and units<=9. A load press with an invalid preset is ignored entirely: no count change, no state change.
- Priority among press pulses arriving in the same cycle: load > pause > start.
- State machine (registered):
  - IDLE:
    - Valid load sets COUNT=PRESET and stays in IDLE.
    - Start with COUNT!=00 goes to RUN. Start with COUNT==00 is ignored.
    - Pause is ignored.
  - RUN:
    - On a tick, COUNT is decremented. If the pre-decrement COUNT is 01, COUNT becomes 00 and the state goes to EXPIRED.
    - Pause goes to PAUSED.
    - Load and start are ignored.
    - Tick and pause in the same cycle: the decrement applies first. If that decrement reaches 00, EXPIRED wins; otherwise the state goes to PAUSED with the decremented value.
  - PAUSED:
    - COUNT holds.
    - Start goes to RUN.
    - Valid load sets COUNT=PRESET and goes to IDLE.
  - EXPIRED:
    - COUNT holds 00.
    - Valid load sets COUNT=PRESET and goes to IDLE.
    - Start and pause are ignored.
- Tick divider:
  - Counts only in RUN and is held at 0 in every other state.
  - A tick occurs in the cycle where the divider equals TICK_DIV_COUNT; the divider then wraps to 0.
  - After any entry into RUN, the first decrement lands exactly TICK_DIV_COUNT+1 clocks later. Resuming from PAUSED restarts a full period.
- BCD decrement:
  - If units==0: units becomes 9 and tens decrements.
  - Otherwise units decrements.
  - Never below 00; no wrap to 59.
- Output timing:
  - COUNT_O, RUNNING_O and EXPIRED_O are registered and change on the same edge as the state.
  - TICK_O is high for exactly the one cycle in which COUNT_O first shows the decremented value.
- Button-to-action latency: 2 synchroniser cycles + DEBOUNCE_COUNT cycles + 1 state update. The action is visible on the outputs within DEBOUNCE_COUNT+4 clocks of the pin falling.

Test Plan (bench overrides DEBOUNCE_COUNT=4, TICK_DIV_COUNT=9):
1. PRESET_I=8'h21, load then start:
   - COUNT_O steps 21 -> 20 -> 19 -> 18 every 10 clocks.
   - TICK_O pulses once per step, aligned with the new value.
   - RUNNING_O=1 throughout.
2. PRESET_I=8'h03, load then start:
   - Exactly 3 ticks: 02, 01, 00.
   - Then EXPIRED_O=1 and RUNNING_O=0.
   - COUNT_O stays 00 for 100 further clocks with no TICK_O.
   - A subsequent start press is ignored.
3. Invalid presets:
   - PRESET_I=8'h5A, then 8'h60, load from IDLE holding 8'h12: COUNT_O stays 12 and the state stays IDLE.
   - Start pressed with COUNT_O=00 in IDLE: RUNNING_O stays 0.
4. Bounce:
   - START_N_I low for 3 clocks, then high: no action.
   - Low for 6 clocks and held for 200: exactly one RUN entry.
   - Toggling the pin every clock for 50 clocks: no action.
5. Pause/resume from COUNT_O=8'h30:
   - Pause press mid-period: COUNT_O holds 30 for 60 clocks.
   - Start press: next decrement to 29 occurs exactly 10 clocks after RUNNING_O rises.
   - Load and start pressed in the same cycle while PAUSED: preset loads, state is IDLE.
6. Reset:
   - Assert RESET_I asynchronously mid-RUN between clock edges: all outputs go to their reset values before the next edge.
   - Deassert RESET_I: the block stays IDLE until button presses arrive.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Settable two-digit BCD seconds countdown (59..00) with debounced pushbutton control.
// Buttons are synchronised and debounced; a debounced press starts, pauses or loads the timer.
module bcd_countdown_timer #(
   parameter int TICK_DIV_COUNT = 49999999,
   parameter int DEBOUNCE_COUNT = 500000
) (
   input  logic       CLOCK_50_I,
   input  logic       RESET_I,
   input  logic       START_N_I,
   input  logic       PAUSE_N_I,
   input  logic       LOAD_N_I,
   input  logic [7:0] PRESET_I,
   output logic [7:0] COUNT_O,
   output logic       RUNNING_O,
   output logic       EXPIRED_O,
   output logic       TICK_O
);

   localparam int DB_W  = $clog2(DEBOUNCE_COUNT + 1);
   localparam int DIV_W = $clog2(TICK_DIV_COUNT + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_COUNT - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV_COUNT);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

   state_t           state;
   logic [2:0]       button_n;
   logic [2:0]       sync_meta;
   logic [2:0]       sync_level;
   logic [2:0]       db_level;
   logic [2:0]       press;
   logic [DB_W-1:0]  db_cnt [3];
   logic [DIV_W-1:0] div_cnt;
   logic             start_press;
   logic             pause_press;
   logic             load_ok;
   logic             preset_valid;
   logic             tick;

   assign button_n = {LOAD_N_I, PAUSE_N_I, START_N_I};

   always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
      if (RESET_I) begin
         sync_meta  <= '1;
         sync_level <= '1;
      end else begin
         sync_meta  <= button_n;
         sync_level <= sync_meta;
      end
   end

   // A level is accepted only after DEBOUNCE_COUNT consecutive samples disagree with the current one.
   always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
      if (RESET_I) begin
         db_level <= '1;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync_level[i] == db_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_level[i] <= sync_level[i];
               db_cnt[i]   <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   always_comb begin
      press = '0;
      for (int i = 0; i < 3; i++)
         press[i] = db_level[i] & ~sync_level[i] & (db_cnt[i] == DB_LAST);
   end

   assign start_press  = press[0];
   assign pause_press  = press[1];
   assign preset_valid = (PRESET_I[7:4] <= 4'd5) && (PRESET_I[3:0] <= 4'd9);
   assign load_ok      = press[2] & preset_valid;
   assign tick         = (state == RUN) && (div_cnt == DIV_LAST);

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v == 8'h00)
         return 8'h00;
      if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   // The divider only advances in RUN, so every entry into RUN starts a fresh full period.
   always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
      if (RESET_I) begin
         state     <= IDLE;
         div_cnt   <= '0;
         COUNT_O   <= 8'h00;
         RUNNING_O <= 1'b0;
         EXPIRED_O <= 1'b0;
         TICK_O    <= 1'b0;
      end else begin
         TICK_O  <= 1'b0;
         div_cnt <= '0;
         case (state)
            IDLE: begin
               if (load_ok) begin
                  COUNT_O <= PRESET_I;
               end else if (start_press && COUNT_O != 8'h00) begin
                  state     <= RUN;
                  RUNNING_O <= 1'b1;
               end
            end
            RUN: begin
               if (tick) begin
                  COUNT_O <= bcd_dec(COUNT_O);
                  TICK_O  <= 1'b1;
                  if (COUNT_O == 8'h01) begin
                     state     <= EXPIRED;
                     RUNNING_O <= 1'b0;
                     EXPIRED_O <= 1'b1;
                  end else if (pause_press) begin
                     state     <= PAUSED;
                     RUNNING_O <= 1'b0;
                  end
               end else if (pause_press) begin
                  state     <= PAUSED;
                  RUNNING_O <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            PAUSED: begin
               if (load_ok) begin
                  COUNT_O <= PRESET_I;
                  state   <= IDLE;
               end else if (!pause_press && start_press) begin
                  state     <= RUN;
                  RUNNING_O <= 1'b1;
               end
            end
            EXPIRED: begin
               if (load_ok) begin
                  COUNT_O   <= PRESET_I;
                  state     <= IDLE;
                  EXPIRED_O <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
